da_feeder: RTL
==============

Name: da_feeder

Overview:
- Initiator side of the distributed-arithmetic FIR core.
- Accepts input samples over a valid/ready stream and keeps a 64-tap sample delay line.
- Per sample, presents 8 bit-sliced 8-bit ROM addresses (MSB slice first) to the DA core, sequences its clear/start/done handshake, captures the accumulator and streams the result out.
- Also arbitrates coefficient-ROM load requests onto the core's CLOAD/CADDR/CIN port.

Parameters:
- SAMPLE_W, 16, input sample width in bits; also the number of DA slices per output.
- TAPS, 64, delay-line depth; fixed at 8 banks x 8 address bits.
- DONE_TIMEOUT, 255, maximum cycles in SLICE_WAIT before error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  SAMPLE_W  two's-complement sample
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_data  out  38  filter output, two's complement
- cfg_valid  in  1  coefficient write request
- cfg_ready  out  1  write accepted
- cfg_addr  in  11  ROM address
- cfg_data  in  19  ROM word
- da_a7..da_a0  out  8 each  slice addresses to DA core
- da_start  out  1  one-cycle slice start pulse
- da_clr  out  1  one-cycle accumulator clear (drives core reset)
- da_cload  out  1  ROM load strobe
- da_caddr  out  11  ROM load address
- da_cin  out  19  ROM load data
- da_done  in  1  one-cycle slice-complete pulse from core
- da_acc  in  38  core accumulator output
- err  out  1  sticky timeout flag

Behaviour:
- Reset: asynchronous, all-zero.
  - State IDLE; delay line, bit counter, timeout counter, out_data all 0.
  - out_valid = 0, err = 0; all da_* outputs 0.
  - in_ready = 0, cfg_ready = 0 while reset is asserted.
  - Reset mid-operation abandons the slice in flight; no partial result is ever emitted.
- Delay line: x[0..63]. On input accept, x[0] <= in_data and x[i] <= x[i-1]; x[63] is discarded.
- Slice address mapping: for bit b, da_ak[j] = x[8k+j][b], for k = 0..7 and j = 0..7.
  - Addresses are registered and held stable from the da_start cycle through the da_done cycle.
- IDLE:
  - in_ready = 1 and cfg_ready = 1 only in IDLE.
  - cfg_valid has priority over in_valid in the same cycle. When both are asserted, cfg_ready = 1 and in_ready = 0.
  - Config accept -> CFG. Sample accept -> CLEAR.
- CFG, 1 cycle:
  - da_cload = 1, with da_caddr and da_cin registered from the accepted request.
  - -> IDLE. Maximum throughput is 1 write per 2 cycles.
- CLEAR, 1 cycle:
  - da_clr = 1; bit counter b <= SAMPLE_W-1.
  - -> START.
- START, 1 cycle:
  - Addresses for bit b are valid; da_start = 1.
  - -> WAIT; timeout counter cleared.
- WAIT:
  - On da_done: if b == 0 -> CAPTURE; else b <= b-1 and -> START.
  - Timeout counter increments each cycle. On reaching DONE_TIMEOUT: err <= 1, -> IDLE, sample dropped, delay line retained.
  - A da_done seen in any state other than WAIT is ignored.
- CAPTURE, 1 cycle: out_data <= da_acc; out_valid <= 1; -> OUTPUT.
- OUTPUT:
  - Hold out_data and out_valid until out_ready is seen; then out_valid <= 0 and -> IDLE.
  - in_ready stays 0 throughout, giving back-pressure.
  - A result is never overwritten.
- Latency from input accept to out_valid:
  - 2 + SAMPLE_W*(1 + core slice latency) + 1 cycles.
  - Minimum spacing between outputs includes one IDLE cycle.
- err clears only on reset.

Test Plan:
- Coefficient load. cfg writes addr 0x001 = 19'h00001 and addr 0x000 = 0, with cfg_valid held high → da_cload pulses on 2 separate cycles with matching caddr/cin; cfg_ready = 0 in each CFG cycle.
- Impulse, with a behavioural DA core model and the ROM programmed for h[0] = 1, others 0.
  - Input 16'h0001 then 63 zeros → first out_data = 38'h1, next 63 outputs = 0 … wait: first output = 1, subsequent outputs = 0 after the impulse shifts past tap 0.
  - Addresses show the 1 walking from da_a0[0] to da_a7[7].
- Negative sample. Input 16'hFFFF with h[0] = 1 → out_data = 38'h3F_FFFF_FFFF.
  - da_clr precedes the first da_start by 1 cycle.
  - Exactly 16 da_start pulses are issued.
- Back-pressure. Hold out_ready = 0 for 20 cycles with in_valid = 1 → out_data stable, in_ready = 0 throughout; release → one output, then the next sample is accepted.
- Simultaneous request. cfg_valid and in_valid both high in IDLE → config is taken first, sample is accepted 2 cycles later, and the result is correct.
- Timeout and reset.
  - Suppress da_done → err = 1 after 255 WAIT cycles, FSM returns to IDLE.
  - Assert reset mid-WAIT → all outputs 0 immediately, err = 0, no out_valid pulse.

Source files
------------

// File: rtl/da_feeder.sv
// da_feeder: sample delay line and bit-slice sequencer feeding a distributed-arithmetic FIR core,
// plus arbitration of coefficient-ROM writes onto the core's load port.
module da_feeder #(
  parameter int SAMPLE_W     = 16,
  parameter int TAPS         = 64,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [37:0]         out_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [10:0]         cfg_addr,
  input  logic [18:0]         cfg_data,
  output logic [7:0]          da_a7,
  output logic [7:0]          da_a6,
  output logic [7:0]          da_a5,
  output logic [7:0]          da_a4,
  output logic [7:0]          da_a3,
  output logic [7:0]          da_a2,
  output logic [7:0]          da_a1,
  output logic [7:0]          da_a0,
  output logic                da_start,
  output logic                da_clr,
  output logic                da_cload,
  output logic [10:0]         da_caddr,
  output logic [18:0]         da_cin,
  input  logic                da_done,
  input  logic [37:0]         da_acc,
  output logic                err
);
  localparam int BW = $clog2(SAMPLE_W);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CFG, CLEAR, START, WAIT, CAPTURE, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [SAMPLE_W-1:0] x_q [TAPS];
  logic [SAMPLE_W-1:0] x_d [TAPS];
  logic [7:0] addr_q [8];
  logic [7:0] addr_d [8];
  logic [BW-1:0] b_q, b_d;
  logic [TW-1:0] to_q, to_d;
  logic [37:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, err_q, err_d;
  logic start_q, start_d, clr_q, clr_d, cload_q, cload_d;
  logic [10:0] caddr_q, caddr_d;
  logic [18:0] cin_q, cin_d;
  assign cfg_ready = state_q == IDLE && !reset;
  assign in_ready  = state_q == IDLE && !cfg_valid && !reset;
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    addr_d      = addr_q;
    b_d         = b_q;
    to_d        = to_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    caddr_d     = caddr_q;
    cin_d       = cin_q;
    start_d     = 1'b0;
    clr_d       = 1'b0;
    cload_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          state_d = CFG;
          cload_d = 1'b1;
          caddr_d = cfg_addr;
          cin_d   = cfg_data;
        end else if (in_valid && in_ready) begin
          x_d[0] = in_data;
          for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          state_d = CLEAR;
          clr_d   = 1'b1;
        end
      end
      CFG: state_d = IDLE;
      CLEAR: begin
        b_d     = BW'(SAMPLE_W - 1);
        state_d = START;
        start_d = 1'b1;
      end
      START: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (da_done) begin
          state_d = b_q == '0 ? CAPTURE : START;
          start_d = b_q != '0;
          b_d     = b_q == '0 ? b_q : b_q - BW'(1);
        end else if (to_q == TW'(DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      CAPTURE: begin
        out_data_d  = da_acc;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        state_d     = out_ready ? IDLE : OUTPUT;
      end
      default: state_d = IDLE;
    endcase
    // Slice addresses are latched on entry to START and held until the next slice.
    if (state_d == START)
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 8; j++) addr_d[k][j] = x_q[8*k+j][b_d];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      addr_q      <= '{default: '0};
      b_q         <= '0;
      to_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      clr_q       <= 1'b0;
      cload_q     <= 1'b0;
      caddr_q     <= '0;
      cin_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      addr_q      <= addr_d;
      b_q         <= b_d;
      to_q        <= to_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      start_q     <= start_d;
      clr_q       <= clr_d;
      cload_q     <= cload_d;
      caddr_q     <= caddr_d;
      cin_q       <= cin_d;
    end
  end
  assign {da_a7, da_a6, da_a5, da_a4} = {addr_q[7], addr_q[6], addr_q[5], addr_q[4]};
  assign {da_a3, da_a2, da_a1, da_a0} = {addr_q[3], addr_q[2], addr_q[1], addr_q[0]};
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign da_start  = start_q;
  assign da_clr    = clr_q;
  assign da_cload  = cload_q;
  assign da_caddr  = caddr_q;
  assign da_cin    = cin_q;
endmodule
